// File: rtl/dff_pipe_pkg.sv
// Shared types and helpers for the dff_pipe_bank register-pipeline bank.
package dff_pipe_pkg;

    // Source of each lane's shift enable.
    typedef enum logic [1:0] {
        EN_PORT = 2'd0,
        EN_HIGH = 2'd1,
        EN_LOW  = 2'd2
    } en_mode_e;

    // Widest data word the replicate helper can build; callers slice down to WIDTH.
    localparam int REP_MAX = 4096;

    // Replicate a single bit across a full-width word (reset/init patterns).
    function automatic logic [REP_MAX-1:0] rep_bit(input logic b);
        return {REP_MAX{b}};
    endfunction

    // Bits needed to count 0..depth valid stages; never less than one bit.
    function automatic int calc_cw(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_lane.sv
// One channel of the bank: DEPTH data stages, a parallel valid shift chain and
// an occupancy counter. The enable arrives already resolved to active-high.
module dff_pipe_lane
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SR_VAL = 0,
    parameter int INIT   = 0,
    parameter int CW     = calc_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             sr,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    fill
);

    // Full-width constant words built from the single-bit reset/init settings.
    localparam logic [REP_MAX-1:0] SR_FULL   = rep_bit(SR_VAL != 0);
    localparam logic [REP_MAX-1:0] INIT_FULL = rep_bit(INIT != 0);
    localparam logic [WIDTH-1:0]   SR_WORD   = SR_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   INIT_WORD = INIT_FULL[WIDTH-1:0];

    // Stage k lives at bits [k*WIDTH +: WIDTH]; stage 0 is the input end.
    // The declaration values are the power-up contents before any reset.
    logic [DEPTH*WIDTH-1:0] data_q  = {DEPTH{INIT_WORD}};
    logic [DEPTH*WIDTH-1:0] data_d;
    logic [DEPTH-1:0]       valid_q = '0;
    logic [DEPTH-1:0]       valid_d;
    logic [CW-1:0]          fill_q  = '0;
    logic [CW-1:0]          fill_d;

    // Next-state: flush clears occupancy and freezes data, enable shifts, else hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fill_d  = fill_q;
        if (flush) begin
            // Data deliberately stays put: a flush only retires the contents.
            valid_d = '0;
            fill_d  = '0;
        end else if (en) begin
            data_d[WIDTH-1:0] = d;
            valid_d[0]        = d_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k*WIDTH +: WIDTH] = data_q[(k-1)*WIDTH +: WIDTH];
                valid_d[k]               = valid_q[k-1];
            end
            // One entry in, one possibly out; the count never leaves 0..DEPTH,
            // and the modular CW-bit arithmetic stays exact within that range.
            fill_d = fill_q + CW'(d_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    // State registers; reset overrides everything and reloads the data pattern.
    always_ff @(posedge clk) begin
        if (sr) begin
            data_q  <= {DEPTH{SR_WORD}};
            valid_q <= '0;
            fill_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs come straight from the last stage's flops.
    assign q       = data_q[(DEPTH-1)*WIDTH +: WIDTH];
    assign q_valid = valid_q[DEPTH-1];
    assign fill    = fill_q;

endmodule

// File: rtl/dff_pipe_bank.sv
// Bank of CHANNELS independent register pipelines. Resolves each lane's
// enable from EN_MODE/EN_INV and instantiates one dff_pipe_lane per channel.
module dff_pipe_bank
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2,
    parameter int EN_MODE  = 0,
    parameter int EN_INV   = 0,
    parameter int SR_VAL   = 0,
    parameter int INIT     = 0,
    parameter int CW       = calc_cw(DEPTH)
) (
    input  logic                      clk,
    input  logic                      sr,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      flush,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       d_valid,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       q_valid,
    output logic [CHANNELS*CW-1:0]    fill
);

    localparam en_mode_e MODE = en_mode_e'(EN_MODE[1:0]);
    localparam logic     INV  = (EN_INV != 0);

    logic [CHANNELS-1:0] e_c;

    // Per-lane active-high enable; an unrecognised mode behaves as tied low.
    always_comb begin
        e_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (MODE)
                EN_PORT: e_c[c] = en[c] ^ INV;
                EN_HIGH: e_c[c] = 1'b1;
                default: e_c[c] = 1'b0;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        dff_pipe_lane #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .SR_VAL (SR_VAL),
            .INIT   (INIT),
            .CW     (CW)
        ) u_lane (
            .clk     (clk),
            .sr      (sr),
            .flush   (flush),
            .en      (e_c[c]),
            .d       (d[c*WIDTH +: WIDTH]),
            .d_valid (d_valid[c]),
            .q       (q[c*WIDTH +: WIDTH]),
            .q_valid (q_valid[c]),
            .fill    (fill[c*CW +: CW])
        );
    end

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Bench for dff_pipe_bank: four differently configured instances share one
// stimulus stream and are compared each cycle with a history-queue model.
module tb_dff_pipe_bank;

    logic        clk = 1'b0;
    logic        sr, flush;
    logic [1:0]  en, d_valid;
    logic [15:0] d;

    logic [15:0] q_o  [4];
    logic [1:0]  qv_o [4];
    logic [5:0]  fill_a, fill_b;
    logic [1:0]  fill_c, fill_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // a: port enable, INIT=1, SR_VAL=0
    dff_pipe_bank #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .EN_MODE(0), .EN_INV(0), .SR_VAL(0), .INIT(1)) u_a (
        .clk(clk), .sr(sr), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_o[0]), .q_valid(qv_o[0]), .fill(fill_a));
    // b: active-low port enable, SR_VAL=1
    dff_pipe_bank #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .EN_MODE(0), .EN_INV(1), .SR_VAL(1), .INIT(0)) u_b (
        .clk(clk), .sr(sr), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_o[1]), .q_valid(qv_o[1]), .fill(fill_b));
    // c: single stage, enable tied high
    dff_pipe_bank #(.WIDTH(8), .DEPTH(1), .CHANNELS(2), .EN_MODE(1), .EN_INV(0), .SR_VAL(0), .INIT(0)) u_c (
        .clk(clk), .sr(sr), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_o[2]), .q_valid(qv_o[2]), .fill(fill_c));
    // d: single stage, enable tied low, SR_VAL=1
    dff_pipe_bank #(.WIDTH(8), .DEPTH(1), .CHANNELS(2), .EN_MODE(2), .EN_INV(0), .SR_VAL(1), .INIT(0)) u_d (
        .clk(clk), .sr(sr), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_o[3]), .q_valid(qv_o[3]), .fill(fill_d));

    function automatic int   dep (input int i); return (i < 2) ? 4 : 1; endfunction
    function automatic int   mode(input int i); return (i == 2) ? 1 : ((i == 3) ? 2 : 0); endfunction
    function automatic logic inv (input int i); return (i == 1); endfunction
    function automatic logic srv (input int i); return (i == 1) || (i == 3); endfunction
    function automatic logic ini (input int i); return (i == 0); endfunction

    function automatic int act_fill(input int i, input int c);
        case (i)
            0:       return int'(fill_a[c*3 +: 3]);
            1:       return int'(fill_b[c*3 +: 3]);
            2:       return int'(fill_c[c]);
            default: return int'(fill_d[c]);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: per lane, the most recent DEPTH accepted words (newest first).
    // q is the word accepted DEPTH enables ago, or the init/reset pattern if
    // fewer than DEPTH words have entered since power-up/reset.
    logic [8:0] hist [4][2][$];
    logic [7:0] base [4][2];

    task automatic model_step(input int i, input int c);
        logic       e;
        logic [8:0] t;
        e = (mode(i) == 0) ? (en[c] ^ inv(i)) : (mode(i) == 1);
        if (sr) begin
            hist[i][c].delete();
            base[i][c] = {8{srv(i)}};
        end else if (flush) begin
            for (int k = 0; k < hist[i][c].size(); k++) begin
                t = hist[i][c][k];
                t[8] = 1'b0;
                hist[i][c][k] = t;
            end
        end else if (e) begin
            hist[i][c].push_front({d_valid[c], d[c*8 +: 8]});
            if (hist[i][c].size() > dep(i)) void'(hist[i][c].pop_back());
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 2; c++)
                base[i][c] = {8{ini(i)}};
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++)
                for (int c = 0; c < 2; c++)
                    model_step(i, c);
        end
    end

    // Every cycle, every instance and lane against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 2; c++) begin
                logic [8:0] ex;
                int         fc;
                if (hist[i][c].size() >= dep(i)) ex = hist[i][c][dep(i)-1];
                else                              ex = {1'b0, base[i][c]};
                fc = 0;
                for (int k = 0; k < hist[i][c].size(); k++) fc += int'(hist[i][c][k][8]);
                check($sformatf("i%0d_l%0d_q", i, c), 32'(q_o[i][c*8 +: 8]), 32'(ex[7:0]));
                check($sformatf("i%0d_l%0d_qv", i, c), 32'(qv_o[i][c]), 32'(ex[8]));
                check($sformatf("i%0d_l%0d_fill", i, c), 32'(act_fill(i, c)), 32'(fc));
            end
        end
    end

    initial begin
        logic [7:0] v, prev;
        logic [15:0] dd;
        logic [1:0]  dvv;
        sr = 1'b0; flush = 1'b0; en = 2'b00; d = '0; d_valid = 2'b00;

        // Power-up contents before any reset
        repeat (3) @(posedge clk);
        #2;
        check("pu_q", 32'(q_o[0]), 32'h0000FFFF);
        check("pu_qv", 32'(qv_o[0]), 32'h0);
        check("pu_fill", 32'(fill_a), 32'h0);

        // Reset then stream 11,22,33,... into lane0 of instance a
        @(negedge clk); sr = 1'b1;
        @(posedge clk); #2;
        check("rst_q", 32'(q_o[0]), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sr = 1'b0; en = 2'b11; d_valid = 2'b11;
            v = 8'(17 * (k + 1));
            d = {8'($urandom), v};
            @(posedge clk); #2;
            check("stream_fill", 32'(fill_a[2:0]), 32'((k + 1 < 4) ? k + 1 : 4));
            if (k >= 3) check("stream_q", 32'(q_o[0][7:0]), 32'(8'(17 * (k - 2))));
        end

        // Instance b: lane0 stalled (en high = inactive), lane1 shifts A5
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            en = 2'b01; d_valid = 2'b11;
            d = {(j == 0) ? 8'hA5 : 8'h00, 8'($urandom)};
            @(posedge clk); #2;
        end
        check("stall_l1_q", 32'(q_o[1][15:8]), 32'hA5);
        check("stall_l0_q", 32'(q_o[1][7:0]), 32'hFF);
        check("stall_l0_fill", 32'(fill_b[2:0]), 32'h0);
        check("stall_l1_fill", 32'(fill_b[5:3]), 32'h4);

        // Flush beats enable on a full pipeline
        check("pre_flush_fill", 32'(fill_a[2:0]), 32'h4);
        prev = q_o[0][7:0];
        @(negedge clk);
        flush = 1'b1; en = 2'b11; d = 16'h9999; d_valid = 2'b11;
        @(posedge clk); #2;
        check("flush_q", 32'(q_o[0][7:0]), 32'(prev));
        check("flush_qv", 32'(qv_o[0][0]), 32'h0);
        check("flush_fill", 32'(fill_a[2:0]), 32'h0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            flush = 1'b0; en = 2'b11; d = 16'h0000; d_valid = 2'b00;
            @(posedge clk); #2;
        end
        check("post_flush_q", 32'(q_o[0][7:0]), 32'h00);

        // Reset wins over flush and enable
        @(negedge clk);
        sr = 1'b1; flush = 1'b1; en = 2'b11; d = 16'h1234; d_valid = 2'b11;
        @(posedge clk); #2;
        check("srpri_b_q", 32'(q_o[1]), 32'h0000FFFF);
        check("srpri_b_qv", 32'(qv_o[1]), 32'h0);
        check("srpri_b_fill", 32'(fill_b), 32'h0);
        check("srpri_a_q", 32'(q_o[0]), 32'h0);

        // Constant enables on single-stage instances
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            sr = 1'b0; flush = 1'b0;
            en = 2'($urandom); d_valid = 2'($urandom); d = 16'($urandom);
            dd = d; dvv = d_valid;
            @(posedge clk); #2;
            check("hi_q", 32'(q_o[2]), 32'(dd));
            check("hi_qv", 32'(qv_o[2]), 32'(dvv));
            check("lo_q", 32'(q_o[3]), 32'h0000FFFF);
            check("lo_fill", 32'(fill_d), 32'h0);
        end

        // Random traffic with occasional flush and reset
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            sr      = ($urandom_range(0, 49) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            en      = 2'($urandom);
            d_valid = 2'($urandom);
            d       = 16'($urandom);
        end
        @(negedge clk);
        sr = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_pipe_bank.md
Name: dff_pipe_bank

Overview:
- Parametrised bank of CHANNELS independent register pipelines, each WIDTH bits wide and DEPTH stages deep, built from the CC_DFF flip-flop family.
- Generalises the single-bit DFF configuration tests: enable polarity, constant-tied enable, set/reset value and power-up init become parameters of a multi-stage, multi-channel structure.
- Adds per-stage valid tracking, a flush, and a per-channel occupancy count.
- Used as a hardware verification target and as a reusable delay line in test designs.

Parameters:
- WIDTH, 8, data bits per channel (>=1)
- DEPTH, 4, pipeline stages per channel (>=1)
- CHANNELS, 2, number of independent lanes (>=1)
- EN_MODE, 0, 0 = enable from en port, 1 = enable tied high, 2 = enable tied low
- EN_INV, 0, 1 = en port is active-low (used only when EN_MODE=0)
- SR_VAL, 0, value loaded into every data bit on reset (0 or 1)
- INIT, 0, power-up value of every data bit before the first reset (0 or 1)
- CW, $clog2(DEPTH+1), derived width of each occupancy count

Ports:
- clk  in  1  rising-edge clock
- sr  in  1  synchronous reset, active-high
- en  in  CHANNELS  per-channel shift enable; polarity set by EN_INV; ignored unless EN_MODE=0
- flush  in  1  clears all valid bits in every channel
- d  in  CHANNELS*WIDTH  lane c occupies bits [c*WIDTH +: WIDTH]
- d_valid  in  CHANNELS  valid flag accompanying d for each lane
- q  out  CHANNELS*WIDTH  last-stage data of each lane
- q_valid  out  CHANNELS  last-stage valid of each lane
- fill  out  CHANNELS*CW  number of valid stages per lane

Behaviour:
- Effective enable for lane c: e_c = en[c]^EN_INV when EN_MODE=0; 1 when EN_MODE=1; 0 when EN_MODE=2.
- Power-up, before any reset: all data stages = {WIDTH{INIT}}; all valid bits = 0; fill = 0.
- Priority on each rising clk edge, evaluated per lane: sr > flush > e_c > hold.
- sr=1: all data stages = {WIDTH{SR_VAL}}; valid = 0; fill = 0. Reset applies to every lane regardless of en or EN_MODE. A reset mid-stream discards all in-flight data.
- flush=1 (sr=0): every valid bit cleared and fill = 0. Data stages hold their values and do not shift, even if e_c=1.
- e_c=1: stage0 <= d lane; stage k <= stage k-1; valid shifts the same way with d_valid entering at stage0.
- Occupancy update on an enabled shift: fill_next = fill + d_valid - valid[DEPTH-1]. Result always stays in 0..DEPTH.
- e_c=0: lane holds data, valid and fill.
- q and q_valid are direct register outputs of stage DEPTH-1, with no combinational path from the inputs.
- Latency: a value presented on d appears on q after exactly DEPTH enabled edges. Cycles with e_c=0 stall the lane without losing data.
- DEPTH=1: a single register stage; fill is 1 bit.
- EN_MODE=2: the pipeline never shifts, so q stays at INIT (or SR_VAL after reset) permanently and fill stays 0.
- Lanes are fully independent; only sr and flush are shared across lanes.

Decomposition:
- Shared package dff_pipe_pkg holds:
  - en_mode_e enum: EN_PORT=0, EN_HIGH=1, EN_LOW=2
  - a replicate-bit helper function
  - a CW calculation function
- One sub-module, dff_pipe_lane, implements one channel: data stages, valid shift and fill counter, taking e_c as a plain active-high enable.
- The top level generates CHANNELS lanes and computes e_c from EN_MODE and EN_INV.

Test Plan (WIDTH=8, DEPTH=4, CHANNELS=2 unless noted):
- Power-up with INIT=1: no sr, en=0 for 3 cycles -> q=16'hFFFF, q_valid=0, fill=0.
- Streaming: sr for 1 cycle (SR_VAL=0), then EN_MODE=0, en=2'b11, lane0 d = 8'h11, 22, 33, 44, 55 with d_valid=1 -> lane0 q=8'h11 on the 4th edge after the first data, then 22, 33, ...; fill rises 1, 2, 3, 4 and holds at 4.
- Stall and independence: EN_INV=1, en[0]=1 (lane0 stalled) while en[1]=0 shifts 8'hA5 -> lane0 q and fill unchanged; lane1 q=8'hA5 after 4 edges.
- Flush vs enable: pipeline full (fill=4), assert flush with en active and d=8'h99 -> next cycle q_valid=0, fill=0, q data unchanged, 8'h99 never captured.
- Reset priority: sr=1 together with flush=1 and en active, SR_VAL=1 -> q=16'hFFFF, q_valid=0, fill=0 next cycle.
- Constant enable (EN_MODE=1 and EN_MODE=2, DEPTH=1): EN_MODE=1 -> q follows d with 1-cycle latency regardless of en; EN_MODE=2 -> q stays at SR_VAL after reset for 10 cycles of toggling d and en.
